ram4x16_access_ctrl: RTL
========================

Name: ram4x16_access_ctrl

Overview:
Request sequencer that sits directly upstream of the 4-word x 16-bit JK-flip-flop memory. It accepts single-word read/write requests over a valid/ready handshake. It drives the memory's address, rw and data-in lines with correct setup, and returns read data over a response handshake. It also provides a one-shot init sequence that zero-fills all four words, because the memory array has no usable clear path.

Parameters:
DATA_W, 16, data width of memory word and request/response data
ADDR_W, 2, address width; memory depth is 2**ADDR_W (4)
READ_LAT, 1, cycles mem_addr is held with mem_rw=0 before mem_rdata is sampled (range 1..3)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request this cycle
req_rw  input  1  1 = write, 0 = read (same polarity as memory rw)
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer accepts read data
rsp_rdata  output  DATA_W  read data
init  input  1  level request to zero-fill memory
init_done  output  1  one-cycle pulse when zero-fill completes
busy  output  1  high in any state other than IDLE
mem_addr  output  ADDR_W  to memory address (decoded by memory)
mem_rw  output  1  to memory rw; 1 = write enable
mem_wdata  output  DATA_W  to memory data in
mem_rdata  input  DATA_W  from memory data out

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mem_rw=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, init_done=0, busy=0, init counter=0.
- Reset mid-operation aborts immediately. mem_rw drops asynchronously so that no partial write reaches memory. A pending response is discarded.
- All mem_* outputs and rsp_* outputs are registered. req_ready is combinational: (state==IDLE) & ~init.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready. A response completes on a rising edge with rsp_valid & rsp_ready.
- States: IDLE, INIT, WRITE, READ_WAIT, RESP.
- IDLE:
  - init=1 -> INIT; init has priority over a simultaneous req_valid, which is not accepted.
  - Accepted write -> WRITE; register mem_addr=req_addr, mem_wdata=req_wdata, mem_rw=1.
  - Accepted read -> READ_WAIT; register mem_addr=req_addr, mem_rw=0, wait counter=READ_LAT-1.
- WRITE:
  - Lasts exactly one cycle; memory captures on the edge leaving WRITE.
  - On that edge, mem_rw<=0 and state goes to IDLE.
  - Accept at edge N gives req_ready high again after edge N+1. Maximum write throughput is one write per 2 cycles.
- READ_WAIT:
  - mem_addr is held and mem_rw=0; the counter decrements each edge.
  - On the edge where counter==0: rsp_rdata<=mem_rdata, rsp_valid<=1, state goes to RESP.
  - Read accepted at edge N gives rsp_valid high after edge N+READ_LAT.
- RESP:
  - rsp_valid and rsp_rdata are held stable until rsp_ready.
  - On the handshake edge, rsp_valid<=0 and state goes to IDLE. rsp_rdata keeps its last value.
  - If rsp_ready is already high on entry, the response completes one cycle after rsp_valid rises.
- INIT:
  - Four cycles with mem_rw=1 and mem_wdata=0; mem_addr steps 0,1,2,3 (2-bit counter, wraps to 0).
  - On the edge leaving address 3: mem_rw<=0, init_done<=1 for one cycle, state goes to IDLE.
  - init is sampled only in IDLE. Deasserting init during INIT does not abort the sequence.
  - If init is still high in IDLE after completion, another INIT starts.
- Requests are never dropped. While busy, req_ready=0 and the requester must hold req_* stable.
- busy=1 in INIT, WRITE, READ_WAIT and RESP.

Test Plan:
- Reset release, then init=1 for one cycle -> mem_rw=1 for exactly 4 cycles with mem_addr 0,1,2,3 and mem_wdata=0; init_done pulses once; busy low afterwards; readback of all four addresses returns 16'h0000.
- Write addr=1 data=16'h7000, then read addr=1 with rsp_ready=1 -> mem_rw high for one cycle only; rsp_valid rises READ_LAT cycles after read accept; rsp_rdata=16'h7000.
- Write 16'hAAAA@0, 16'h5555@1, 16'hCCCC@2, 16'h0F0F@3 back-to-back with req_valid held high -> req_ready toggles 1,0 per write; reads return each value; addr 2 is not corrupted by the addr 3 write.
- Read addr=3 with rsp_ready=0 for 5 cycles -> rsp_valid stays high and rsp_rdata=16'h0F0F stable; req_ready=0 throughout; a single rsp_ready pulse completes the response and returns to IDLE.
- Same cycle init=1 and req_valid=1 (write 16'hFFFF@2) -> init wins; the write is accepted only after init_done; final read of addr 2 returns 16'hFFFF.
- reset=0 asserted during a WRITE cycle, and separately during RESP -> mem_rw=0 and rsp_valid=0 immediately; after release, busy=0 and req_ready=1.

Source files
------------

// File: rtl/ram4x16_access_ctrl.sv
// Request sequencer in front of the 4x16 JK-flip-flop memory.
// Single-word read/write requests arrive on a valid/ready handshake; read
// data leaves on a response handshake. A one-shot init sequence zero-fills
// every word because the memory array has no clear path of its own.
`timescale 1ns/1ps
module ram4x16_access_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter int READ_LAT = 1    // 1..3 cycles of address hold before sampling
) (
  input  logic              clk,
  input  logic              reset,      // async, active low
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init,
  output logic              init_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT      = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ_WAIT = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic [1:0] RD_WAIT = 2'(READ_LAT - 1);

  logic [2:0] state;
  logic [1:0] wait_cnt;

  // init is checked ahead of req_valid, so blocking ready on init keeps a
  // simultaneous request from being consumed while the zero-fill starts
  assign req_ready = (state == S_IDLE) & ~init;
  assign busy      = (state != S_IDLE);

  // Main sequencer. The async reset also drops mem_rw at once so an
  // interrupted write never reaches the array. During INIT, mem_addr
  // itself serves as the fill counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_rw    <= 1'b0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init) begin
            state     <= S_INIT;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw    <= 1'b1;
          end else if (req_valid) begin
            mem_addr <= req_addr;
            if (req_rw) begin
              mem_wdata <= req_wdata;
              mem_rw    <= 1'b1;
              state     <= S_WRITE;
            end else begin
              mem_rw   <= 1'b0;
              wait_cnt <= RD_WAIT;
              state    <= S_READ_WAIT;
            end
          end
        end
        S_INIT: begin
          if (mem_addr == '1) begin
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        S_WRITE: begin
          // memory captures on this edge; one write cycle only
          mem_rw <= 1'b0;
          state  <= S_IDLE;
        end
        S_READ_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rsp_rdata <= mem_rdata;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_RESP: begin
          // rsp_rdata keeps its last value after the handshake
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          mem_rw <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
